serial_tx: RTL

Parallel-to-serial byte transmitter. It accepts a data word over a valid/ready handshake and emits it on a single serial line as a frame: one start bit (0), DATA_W data bits LSB-first, then one stop bit (1). Each bit is held for CLKS_PER_BIT clocks. It is the transmit end of the serial link whose receive end is a chain of synchronous D flip-flops that sample the line.

---
 rtl/serial_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// serial_tx: frames a DATA_W-bit word as start(0), data LSB-first, stop(1)
// and shifts it out on tx_line, each bit held for CLKS_PER_BIT clocks.
//
// Ports:
//   clock    - single clock, all state on its rising edge
//   rst      - synchronous active-high reset, dominates all inputs
//   tx_data  - word to send, captured on the accepting edge only
//   tx_valid - tx_data is valid
//   tx_ready - block can accept a word this cycle (IDLE only)
//   tx_line  - serial output, idles high
//   busy     - a frame is in progress
//   tx_done  - one-cycle pulse in the last cycle of the stop bit
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              tx_done
);

  // Counters keep at least one bit so the
  // CLKS_PER_BIT=1 / DATA_W=1 corners stay legal.
  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] T_MAX =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_MAX =
    IW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state;
  logic [TW-1:0]     timer;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;

  logic bit_end;
  logic accept;

  assign bit_end = (timer == T_MAX);
  assign accept  = (state == S_IDLE) && tx_valid;

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          timer <= '0;
          idx   <= '0;
          if (accept) begin
            shreg <= tx_data;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            timer <= '0;
            idx   <= '0;
            state <= S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            shreg <= shreg >> 1;
            if (idx == I_MAX) begin
              idx   <= '0;
              state <= S_STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so
  // tx_valid/tx_data never reach tx_line directly.
  always_comb begin
    tx_line  = 1'b1;
    tx_ready = 1'b0;
    busy     = 1'b1;
    tx_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
      end
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = shreg[0];
      S_STOP:  tx_done = bit_end;
      default: begin
        tx_ready = 1'b0;
      end
    endcase
  end

endmodule
